// File: rtl/flash_pkg.sv
// Shared command bytes, status-register bit positions and FSM encodings
// for the StrataFlash command sequencer.
package flash_pkg;

    localparam logic [7:0] CMD_READ_ARRAY   = 8'hFF;
    localparam logic [7:0] CMD_PROGRAM      = 8'h40;
    localparam logic [7:0] CMD_READ_STATUS  = 8'h70;
    localparam logic [7:0] CMD_CLEAR_STATUS = 8'h50;

    localparam int SR_READY    = 7;
    localparam int SR_PROG_ERR = 4;
    localparam int SR_VPP_ERR  = 3;
    localparam int SR_LOCK_ERR = 1;

    localparam logic [7:0] SR_ERR_MASK =
        8'((1 << SR_PROG_ERR) | (1 << SR_VPP_ERR) | (1 << SR_LOCK_ERR));

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        STEP,
        FINISH
    } seq_state_e;

    // Which bus cycle of the flash sequence was issued most recently.
    typedef enum logic [2:0] {
        SQ_ARRAY_ENTER,
        SQ_READ_DATA,
        SQ_PROG_SETUP,
        SQ_PROG_DATA,
        SQ_STATUS_CMD,
        SQ_POLL,
        SQ_CLEAR,
        SQ_ARRAY_EXIT
    } seq_step_e;

    function automatic logic statusHasError(input logic [7:0] sr);
        return |(sr & SR_ERR_MASK);
    endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// Runs one bridge bus cycle: latches the request, strobes fb_start for a
// single cycle, holds the bus until fb_done and captures read data.
module flash_bus_cycle
    import flash_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic       reqRw_i,
    input  logic [7:0] reqAddr_i,
    input  logic [7:0] reqWdata_i,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic [7:0] fbAddr_o,
    output logic [7:0] fbWdata_o,
    output logic       fbRw_o,
    output logic       fbStart_o,
    input  logic       fbDone_i,
    input  logic [7:0] fbRdata_i
);

    logic       pending_q;
    logic       start_q;
    logic       rw_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;

    // A completion only counts while a cycle is outstanding, so stray
    // fb_done pulses (e.g. from a cycle abandoned by reset) are dropped.
    assign done_o = pending_q & fbDone_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            start_q   <= 1'b0;
            rw_q      <= BUS_READ;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
        end else begin
            start_q <= 1'b0;
            if (req_i && !pending_q) begin
                pending_q <= 1'b1;
                start_q   <= 1'b1;
                rw_q      <= reqRw_i;
                addr_q    <= reqAddr_i;
                wdata_q   <= reqWdata_i;
            end else if (done_o) begin
                pending_q <= 1'b0;
                if (rw_q == BUS_READ) begin
                    rdata_q <= fbRdata_i;
                end
            end
        end
    end

    assign rdata_o   = rdata_q;
    assign fbAddr_o  = addr_q;
    assign fbWdata_o = wdata_q;
    assign fbRw_o    = rw_q;
    assign fbStart_o = start_q;

endmodule

// File: rtl/flash_cmd_seq.sv
// Turns single read/program byte requests into StrataFlash command
// sequences and drives them one bus cycle at a time into the bridge.
module flash_cmd_seq
    import flash_pkg::*;
#(
    parameter logic [15:0] POLL_MAX = 16'd50000
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       cmd_start,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] cmd_rdata,
    output logic       cmd_busy,
    output logic       cmd_done,
    output logic       cmd_error,
    output logic [7:0] fb_addr,
    output logic [7:0] fb_wdata,
    input  logic [7:0] fb_rdata,
    output logic       fb_rw,
    output logic       fb_start,
    input  logic       fb_done
);

    seq_state_e  state_q, state_d;
    seq_step_e   step_q, step_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [15:0] pollCnt_q, pollCnt_d;
    logic        errPend_q, errPend_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        req;
    logic        reqRw;
    logic [7:0]  reqAddr;
    logic [7:0]  reqWdata;
    logic        busDone;
    logic [7:0]  busRdata;

    flash_bus_cycle u_bus (
        .clk_i      (CLK_50MHZ),
        .rst_i      (RST),
        .req_i      (req),
        .reqRw_i    (reqRw),
        .reqAddr_i  (reqAddr),
        .reqWdata_i (reqWdata),
        .done_o     (busDone),
        .rdata_o    (busRdata),
        .fbAddr_o   (fb_addr),
        .fbWdata_o  (fb_wdata),
        .fbRw_o     (fb_rw),
        .fbStart_o  (fb_start),
        .fbDone_i   (fb_done),
        .fbRdata_i  (fb_rdata)
    );

    // STEP picks the next bus cycle from the last one issued and, while
    // polling, from the status byte just read back.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        pollCnt_d = pollCnt_q;
        errPend_d = errPend_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        rdata_d   = rdata_q;
        req       = 1'b0;
        reqRw     = BUS_WRITE;
        reqAddr   = addr_q;
        reqWdata  = CMD_READ_ARRAY;

        unique case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    pollCnt_d = 16'd0;
                    errPend_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ISSUE;
                    req       = 1'b1;
                    reqAddr   = cmd_addr;
                    if (cmd_write) begin
                        step_d   = SQ_PROG_SETUP;
                        reqWdata = CMD_PROGRAM;
                    end else begin
                        step_d   = SQ_ARRAY_ENTER;
                        reqWdata = CMD_READ_ARRAY;
                    end
                end
            end
            ISSUE, WAIT: begin
                state_d = busDone ? STEP : WAIT;
            end
            STEP: begin
                state_d = ISSUE;
                req     = 1'b1;
                unique case (step_q)
                    SQ_ARRAY_ENTER: begin
                        step_d = SQ_READ_DATA;
                        reqRw  = BUS_READ;
                    end
                    SQ_PROG_SETUP: begin
                        step_d   = SQ_PROG_DATA;
                        reqWdata = wdata_q;
                    end
                    SQ_PROG_DATA: begin
                        step_d   = SQ_STATUS_CMD;
                        reqWdata = CMD_READ_STATUS;
                    end
                    SQ_STATUS_CMD, SQ_POLL: begin
                        if (step_q == SQ_POLL && busRdata[SR_READY]) begin
                            if (statusHasError(busRdata)) begin
                                step_d    = SQ_CLEAR;
                                reqWdata  = CMD_CLEAR_STATUS;
                                errPend_d = 1'b1;
                            end else begin
                                step_d   = SQ_ARRAY_EXIT;
                                reqWdata = CMD_READ_ARRAY;
                            end
                        end else if (step_q == SQ_POLL && pollCnt_q >= POLL_MAX) begin
                            step_d    = SQ_CLEAR;
                            reqWdata  = CMD_CLEAR_STATUS;
                            errPend_d = 1'b1;
                        end else begin
                            step_d = SQ_POLL;
                            reqRw  = BUS_READ;
                            if (pollCnt_q < POLL_MAX) begin
                                pollCnt_d = pollCnt_q + 16'd1;
                            end
                        end
                    end
                    SQ_CLEAR: begin
                        step_d   = SQ_ARRAY_EXIT;
                        reqWdata = CMD_READ_ARRAY;
                    end
                    SQ_READ_DATA: begin
                        req     = 1'b0;
                        state_d = FINISH;
                        done_d  = 1'b1;
                        error_d = 1'b0;
                        rdata_d = busRdata;
                    end
                    SQ_ARRAY_EXIT: begin
                        req     = 1'b0;
                        state_d = FINISH;
                        done_d  = 1'b1;
                        error_d = errPend_q;
                    end
                    default: begin
                        req     = 1'b0;
                        state_d = IDLE;
                    end
                endcase
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state_q   <= IDLE;
            step_q    <= SQ_ARRAY_ENTER;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            pollCnt_q <= 16'd0;
            errPend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            rdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            pollCnt_q <= pollCnt_d;
            errPend_q <= errPend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            rdata_q   <= rdata_d;
        end
    end

    assign cmd_busy  = busy_q;
    assign cmd_done  = done_q;
    assign cmd_error = error_q;
    assign cmd_rdata = rdata_q;

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Directed bench for flash_cmd_seq: a small bridge model records every bus
// cycle and answers reads from a queue of hand-chosen values.
module tb_flash_cmd_seq;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmdStart;
    logic       cmdWrite;
    logic [7:0] cmdAddr;
    logic [7:0] cmdWdata;
    logic [7:0] cmdRdata;
    logic       cmdBusy;
    logic       cmdDone;
    logic       cmdError;
    logic [7:0] fbAddr;
    logic [7:0] fbWdata;
    logic [7:0] fbRdata;
    logic       fbRw;
    logic       fbStart;
    logic       fbDone;

    int checks = 0;
    int errors = 0;

    int          negCnt = 0;
    int          lastDoneNeg = -1;
    int          countdown = 0;
    bit          prevBusy = 1'b0;
    bit          outstanding = 1'b0;
    bit          aborted = 1'b0;
    bit          curRead = 1'b0;
    logic [16:0] heldReq = '0;
    int          doneCount = 0;
    int          overlapErr = 0;
    int          gapErr = 0;
    int          holdErr = 0;
    int          doneGapErr = 0;
    logic [7:0]  readVals[$];
    logic [16:0] trace[$];
    logic [16:0] expTrace[$];

    flash_cmd_seq #(.POLL_MAX(16'd4)) dut (
        .CLK_50MHZ (clock),
        .RST       (reset),
        .cmd_start (cmdStart),
        .cmd_write (cmdWrite),
        .cmd_addr  (cmdAddr),
        .cmd_wdata (cmdWdata),
        .cmd_rdata (cmdRdata),
        .cmd_busy  (cmdBusy),
        .cmd_done  (cmdDone),
        .cmd_error (cmdError),
        .fb_addr   (fbAddr),
        .fb_wdata  (fbWdata),
        .fb_rdata  (fbRdata),
        .fb_rw     (fbRw),
        .fb_start  (fbStart),
        .fb_done   (fbDone)
    );

    always #10 clock = ~clock;

    // Bridge model: two-cycle latency, plus protocol watchdogs on the bus.
    initial begin
        fbDone  = 1'b0;
        fbRdata = 8'h00;
        forever begin
            @(negedge clock);
            negCnt++;
            if (reset) aborted = 1'b1;
            if (cmdDone) begin
                doneCount++;
                if (negCnt - lastDoneNeg != 2) doneGapErr++;
            end
            if (fbStart && outstanding) overlapErr++;
            if (outstanding && !aborted && !reset && !fbStart &&
                {fbRw, fbAddr, fbWdata} != heldReq) holdErr++;
            fbDone = 1'b0;
            if (outstanding) begin
                countdown--;
                if (countdown == 0) begin
                    fbDone  = 1'b1;
                    fbRdata = 8'h00;
                    if (curRead && readVals.size() > 0) fbRdata = readVals.pop_front();
                    outstanding = 1'b0;
                    aborted     = 1'b0;
                    lastDoneNeg = negCnt;
                end
            end
            if (fbStart && !reset) begin
                if (prevBusy && (negCnt - lastDoneNeg != 2)) gapErr++;
                heldReq = {fbRw, fbAddr, fbWdata};
                trace.push_back(fbRw ? {1'b1, fbAddr, 8'h00} : {1'b0, fbAddr, fbWdata});
                curRead     = fbRw;
                outstanding = 1'b1;
                countdown   = 2;
            end
            prevBusy = cmdBusy;
        end
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] a, input logic [7:0] d);
        tick();
        cmdStart = 1'b1;
        cmdWrite = wr;
        cmdAddr  = a;
        cmdWdata = d;
        tick();
        cmdStart = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int limit);
        int n = 0;
        while (!cmdDone && n < limit) begin
            tick();
            n++;
        end
        checkOutput({tag, " done seen"}, 32'(cmdDone), 32'd1);
    endtask

    function automatic logic [16:0] busW(input logic [7:0] a, input logic [7:0] d);
        return {1'b0, a, d};
    endfunction

    function automatic logic [16:0] busR(input logic [7:0] a);
        return {1'b1, a, 8'h00};
    endfunction

    task automatic expectRead(input logic [7:0] a);
        expTrace.delete();
        expTrace.push_back(busW(a, 8'hFF));
        expTrace.push_back(busR(a));
    endtask

    task automatic expectProgram(input logic [7:0] a, input logic [7:0] d, input int reads, input bit clear);
        expTrace.delete();
        expTrace.push_back(busW(a, 8'h40));
        expTrace.push_back(busW(a, d));
        expTrace.push_back(busW(a, 8'h70));
        for (int i = 0; i < reads; i++) expTrace.push_back(busR(a));
        if (clear) expTrace.push_back(busW(a, 8'h50));
        expTrace.push_back(busW(a, 8'hFF));
    endtask

    task automatic checkTrace(input string tag);
        logic [16:0] got;
        checkOutput({tag, " trace len"}, 32'(trace.size()), 32'(expTrace.size()));
        for (int i = 0; i < expTrace.size(); i++) begin
            got = (i < trace.size()) ? trace[i] : 17'h1FFFF;
            checkOutput($sformatf("%s trace[%0d]", tag, i), 32'(got), 32'(expTrace[i]));
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " busy"}, 32'(cmdBusy), 32'd0);
        checkOutput({tag, " done"}, 32'(cmdDone), 32'd0);
        checkOutput({tag, " error"}, 32'(cmdError), 32'd0);
        checkOutput({tag, " fb_start"}, 32'(fbStart), 32'd0);
        checkOutput({tag, " fb_rw"}, 32'(fbRw), 32'd1);
        checkOutput({tag, " fb_addr"}, 32'(fbAddr), 32'h00);
        checkOutput({tag, " fb_wdata"}, 32'(fbWdata), 32'h00);
        checkOutput({tag, " rdata"}, 32'(cmdRdata), 32'h00);
    endtask

    task automatic runCommand(input string tag, input logic wr, input logic [7:0] a,
                              input logic [7:0] d, input logic expErr,
                              input bit chkData, input logic [7:0] expData);
        trace.delete();
        doneCount = 0;
        applyStimulus(wr, a, d);
        checkOutput({tag, " accept busy"}, 32'(cmdBusy), 32'd1);
        checkOutput({tag, " accept fb_start"}, 32'(fbStart), 32'd1);
        waitDone(tag, 200);
        checkOutput({tag, " busy at done"}, 32'(cmdBusy), 32'd1);
        checkOutput({tag, " error"}, 32'(cmdError), 32'(expErr));
        if (chkData) checkOutput({tag, " rdata"}, 32'(cmdRdata), 32'(expData));
        tick();
        checkOutput({tag, " busy after"}, 32'(cmdBusy), 32'd0);
        repeat (3) tick();
        checkOutput({tag, " done pulses"}, 32'(doneCount), 32'd1);
        checkTrace(tag);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        cmdStart = 1'b0;
        cmdWrite = 1'b0;
        cmdAddr  = 8'h00;
        cmdWdata = 8'h00;
        repeat (3) tick();
        checkResetValues("reset");
        reset = 1'b0;
        tick();

        readVals.delete(); readVals.push_back(8'hA5);
        expectRead(8'h12);
        runCommand("read", 1'b0, 8'h12, 8'h00, 1'b0, 1'b1, 8'hA5);

        readVals.delete(); readVals.push_back(8'h00); readVals.push_back(8'h00); readVals.push_back(8'h80);
        expectProgram(8'h20, 8'h3C, 3, 1'b0);
        runCommand("prog ok", 1'b1, 8'h20, 8'h3C, 1'b0, 1'b0, 8'h00);

        readVals.delete(); readVals.push_back(8'h90);
        expectProgram(8'h21, 8'h11, 1, 1'b1);
        runCommand("prog err", 1'b1, 8'h21, 8'h11, 1'b1, 1'b0, 8'h00);

        readVals.delete(); readVals.push_back(8'h82);
        expectProgram(8'h22, 8'h22, 1, 1'b1);
        runCommand("lock err", 1'b1, 8'h22, 8'h22, 1'b1, 1'b0, 8'h00);

        readVals.delete(); readVals.push_back(8'h00); readVals.push_back(8'hC4);
        expectProgram(8'h23, 8'h33, 2, 1'b0);
        runCommand("benign bits", 1'b1, 8'h23, 8'h33, 1'b0, 1'b0, 8'h00);

        readVals.delete();
        expectProgram(8'h30, 8'h5A, 4, 1'b1);
        runCommand("timeout", 1'b1, 8'h30, 8'h5A, 1'b1, 1'b0, 8'h00);

        // Reset lands during the second status read; error and rdata are nonzero beforehand.
        readVals.delete();
        trace.delete();
        doneCount = 0;
        applyStimulus(1'b1, 8'h40, 8'h77);
        n = 0;
        while (trace.size() < 5 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("rst reached poll 2", 32'(trace.size()), 32'd5);
        reset = 1'b1;
        tick();
        checkResetValues("rst mid");
        reset = 1'b0;
        repeat (8) tick();
        checkOutput("rst no done", 32'(doneCount), 32'd0);
        checkOutput("rst idle busy", 32'(cmdBusy), 32'd0);
        readVals.delete(); readVals.push_back(8'hC3);
        expectRead(8'h40);
        runCommand("read after rst", 1'b0, 8'h40, 8'h00, 1'b0, 1'b1, 8'hC3);

        readVals.delete(); readVals.push_back(8'h00); readVals.push_back(8'h00);
        readVals.push_back(8'h00); readVals.push_back(8'h80);
        expectProgram(8'h31, 8'h66, 4, 1'b0);
        runCommand("ready at max", 1'b1, 8'h31, 8'h66, 1'b0, 1'b0, 8'h00);

        // cmd_start held high: the second command must wait for the cycle after cmd_done.
        readVals.delete(); readVals.push_back(8'h5A); readVals.push_back(8'h6B);
        trace.delete();
        doneCount = 0;
        tick();
        cmdStart = 1'b1;
        cmdWrite = 1'b0;
        cmdAddr  = 8'h12;
        tick();
        checkOutput("b2b accept busy", 32'(cmdBusy), 32'd1);
        cmdAddr = 8'h55;
        waitDone("b2b first", 200);
        checkOutput("b2b first rdata", 32'(cmdRdata), 32'h5A);
        checkOutput("b2b first trace len", 32'(trace.size()), 32'd2);
        tick();
        checkOutput("b2b gap busy", 32'(cmdBusy), 32'd0);
        checkOutput("b2b gap fb_start", 32'(fbStart), 32'd0);
        tick();
        checkOutput("b2b second busy", 32'(cmdBusy), 32'd1);
        checkOutput("b2b second fb_start", 32'(fbStart), 32'd1);
        checkOutput("b2b second fb_addr", 32'(fbAddr), 32'h55);
        cmdStart = 1'b0;
        waitDone("b2b second", 200);
        checkOutput("b2b second rdata", 32'(cmdRdata), 32'h6B);
        repeat (4) tick();
        checkOutput("b2b done pulses", 32'(doneCount), 32'd2);
        expTrace.delete();
        expTrace.push_back(busW(8'h12, 8'hFF));
        expTrace.push_back(busR(8'h12));
        expTrace.push_back(busW(8'h55, 8'hFF));
        expTrace.push_back(busR(8'h55));
        checkTrace("b2b");

        checkOutput("fb_start overlap", 32'(overlapErr), 32'd0);
        checkOutput("fb_start spacing", 32'(gapErr), 32'd0);
        checkOutput("bus hold", 32'(holdErr), 32'd0);
        checkOutput("cmd_done spacing", 32'(doneGapErr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
